// File: rtl/debug_dump_tx_pkg.sv
// ============================================================================
// debug_dump_tx_pkg
//   Shared definitions for the debug-dump frame serializer: frame sync nibble,
//   debug source identifiers (same codes as the debug command set), FSM state
//   encoding and a small helper that builds the header byte.
// ============================================================================
package debug_dump_tx_pkg;

    // Upper nibble of every frame header byte.
    localparam logic [3:0] FRAME_SYNC = 4'hA;

    // Debug source tags. The values line up with the debug command codes so
    // the controller can forward its command code straight into i_src_id.
    typedef enum logic [3:0] {
        SRC_NONE   = 4'd0,
        SRC_REGS   = 4'd1,
        SRC_IF_ID  = 4'd2,
        SRC_ID_EX  = 4'd3,
        SRC_EX_MEM = 4'd4,
        SRC_MEM_WB = 4'd5,
        SRC_MEM    = 4'd6
    } src_id_e;

    // Frame serializer states, in transmit order.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    // Header byte: sync nibble on top, source tag in the low nibble.
    function automatic logic [7:0] header_byte(input logic [3:0] src);
        return {FRAME_SYNC, src};
    endfunction

endpackage

// File: rtl/debug_dump_tx.sv
// ============================================================================
// debug_dump_tx
//   Frame serializer between the debug controller and the UART TX FIFO.
//   On i_start (in IDLE) a wide debug vector is captured and sent as:
//       header {4'hA, src} | length | payload bytes (LSB byte first) | checksum
//   The checksum is the XOR of the length byte and all payload bytes, which
//   makes it 8'h00 for an empty frame. One byte is pushed per cycle in which
//   the FIFO is not full; the FSM only advances on such cycles.
//
// Ports
//   i_clk        in   1          system clock, rising edge
//   i_reset_n    in   1          asynchronous active-low reset
//   i_start      in   1          1-cycle frame request, sampled only in IDLE
//   i_src_id     in   4          source tag for the header low nibble
//   i_payload    in   MAX_BITS   snapshot data, byte k = i_payload[8k +: 8]
//   i_num_bytes  in   LEN_W      payload byte count (clamped to MAX_BYTES)
//   i_abort      in   1          cancel the frame in progress
//   i_tx_full    in   1          UART TX FIFO full
//   o_tx_write   out  1          FIFO write strobe (combinational on i_tx_full)
//   o_tx_data    out  8          byte presented with o_tx_write
//   o_busy       out  1          high from capture until frame end
//   o_done       out  1          1-cycle pulse after the checksum byte
// ============================================================================
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int MAX_BITS  = 1024,
    parameter int MAX_BYTES = MAX_BITS / 8,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [3:0]          i_src_id,
    input  logic [MAX_BITS-1:0] i_payload,
    input  logic [LEN_W-1:0]    i_num_bytes,
    input  logic                i_abort,
    input  logic                i_tx_full,
    output logic                o_tx_write,
    output logic [7:0]          o_tx_data,
    output logic                o_busy,
    output logic                o_done
);

    // Byte index width within the snapshot, and the matching bit index width
    // for the indexed part-select.
    localparam int BIDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int IDX_W  = BIDX_W + 3;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_e              state;
    logic [MAX_BITS-1:0] snap;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    cnt;
    logic [3:0]          src;
    logic [7:0]          csum;

    logic [LEN_W-1:0]    len_clamped;
    logic [7:0]          len_byte;
    logic [IDX_W-1:0]    bit_idx;
    logic [7:0]          data_byte;
    logic                last_data;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign len_clamped = (i_num_bytes > MAX_LEN) ? MAX_LEN : i_num_bytes;
    assign len_byte    = 8'(len);

    // Byte select straight out of the snapshot register; cnt never exceeds
    // MAX_BYTES-1 while in DATA, so its low BIDX_W bits are the full index.
    assign bit_idx   = {cnt[BIDX_W-1:0], 3'b000};
    assign data_byte = snap[bit_idx +: 8];
    assign last_data = (cnt == (len - ONE));

    // A byte leaves on any active-state cycle the FIFO can take it, unless
    // the frame is being aborted this very cycle.
    assign o_tx_write = (state != ST_IDLE) && !i_tx_full && !i_abort;

    // Byte on the bus depends only on registered state, so it holds steady
    // through any number of stalled cycles.
    // NOTE: every output of a combinational block gets a default assignment
    // before the case so that no path leaves it unassigned and infers a latch.
    always_comb begin
        o_tx_data = 8'h00;
        case (state)
            ST_HDR:  o_tx_data = header_byte(src);
            ST_LEN:  o_tx_data = len_byte;
            ST_DATA: o_tx_data = data_byte;
            ST_CSUM: o_tx_data = csum;
            default: o_tx_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            // NOTE: the snapshot store is wide but is still cleared on reset,
            // so no stale debug data can ever be observed after a reset.
            snap   <= '0;
            len    <= '0;
            cnt    <= '0;
            src    <= 4'h0;
            csum   <= 8'h00;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        snap   <= i_payload;
                        len    <= len_clamped;
                        src    <= i_src_id;
                        cnt    <= '0;
                        csum   <= 8'h00;
                        o_busy <= 1'b1;
                        state  <= ST_HDR;
                    end
                end

                ST_HDR, ST_LEN, ST_DATA, ST_CSUM: begin
                    if (i_abort) begin
                        // Bytes already in the FIFO stay there; no o_done.
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (o_tx_write) begin
                        case (state)
                            ST_HDR: begin
                                state <= ST_LEN;
                            end
                            ST_LEN: begin
                                csum  <= csum ^ len_byte;
                                state <= (len == '0) ? ST_CSUM : ST_DATA;
                            end
                            ST_DATA: begin
                                csum <= csum ^ data_byte;
                                cnt  <= cnt + ONE;
                                if (last_data) begin
                                    state <= ST_CSUM;
                                end
                            end
                            default: begin
                                // Checksum byte written: frame complete.
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    // Unreachable encodings recover to IDLE.
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed self-checking bench for debug_dump_tx.
module tb_debug_dump_tx;

    typedef logic [7:0] byte_q_t[$];

    logic          i_clk;
    logic          i_reset_n;
    logic          i_start;
    logic [3:0]    i_src_id;
    logic [1023:0] i_payload;
    logic [7:0]    i_num_bytes;
    logic          i_abort;
    logic          i_tx_full;
    logic          o_tx_write;
    logic [7:0]    o_tx_data;
    logic          o_busy;
    logic          o_done;

    int vectors;
    int miscompares;

    debug_dump_tx dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_src_id    (i_src_id),
        .i_payload   (i_payload),
        .i_num_bytes (i_num_bytes),
        .i_abort     (i_abort),
        .i_tx_full   (i_tx_full),
        .o_tx_write  (o_tx_write),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Reference frame: header, clamped length, payload bytes, XOR of length
    // and payload bytes.
    function automatic byte_q_t model_frame(input logic [3:0] src, input int nb,
                                            input logic [1023:0] pl);
        byte_q_t    q;
        int         len;
        logic [7:0] cs;
        logic [7:0] b;
        len = (nb > 128) ? 128 : nb;
        q.push_back({4'hA, src});
        q.push_back(8'(len));
        cs = 8'(len);
        for (int k = 0; k < len; k++) begin
            b = pl[8*k +: 8];
            q.push_back(b);
            cs ^= b;
        end
        q.push_back(cs);
        return q;
    endfunction

    // Issue a start in the current cycle, then follow the frame byte by byte.
    // tx_full is raised on cycles stall_lo..stall_hi (cycle 1 = first after
    // start). On cycle 'poke' a second start with different inputs is
    // attempted. Returns positioned inside the o_done cycle.
    task automatic run_frame(input string tag, input logic [3:0] src,
                             input logic [7:0] nb, input logic [1023:0] pl,
                             input byte_q_t exp, input int stall_lo,
                             input int stall_hi, input int poke,
                             input int done_cyc);
        int c;
        int idx;
        i_start     = 1'b1;
        i_src_id    = src;
        i_num_bytes = nb;
        i_payload   = pl;
        i_abort     = 1'b0;
        i_tx_full   = 1'b0;
        #1;
        check({tag, "/idle_busy"}, 32'(o_busy), 32'd0);
        check({tag, "/idle_wr"}, 32'(o_tx_write), 32'd0);
        cyc();
        c   = 1;
        idx = 0;
        while (idx < exp.size() && c < 600) begin
            i_tx_full = (c >= stall_lo && c <= stall_hi);
            if (poke != 0 && c == poke) begin
                i_start     = 1'b1;
                i_src_id    = ~src;
                i_num_bytes = 8'd9;
                i_payload   = ~pl;
            end else begin
                i_start = 1'b0;
            end
            #1;
            check($sformatf("%s/wr_c%0d", tag, c), 32'(o_tx_write), 32'(!i_tx_full));
            check($sformatf("%s/byte%0d", tag, idx), 32'(o_tx_data), 32'(exp[idx]));
            check($sformatf("%s/busy_c%0d", tag, c), 32'(o_busy), 32'd1);
            if (!i_tx_full) idx++;
            cyc();
            c++;
        end
        i_tx_full = 1'b0;
        i_start   = 1'b0;
        #1;
        check({tag, "/bytes_sent"}, 32'(idx), 32'(exp.size()));
        check({tag, "/done_cycle"}, 32'(c), 32'(done_cyc));
        check({tag, "/done"}, 32'(o_done), 32'd1);
        check({tag, "/done_busy"}, 32'(o_busy), 32'd0);
        check({tag, "/done_wr"}, 32'(o_tx_write), 32'd0);
    endtask

    initial begin
        logic [1023:0] pl1;
        logic [1023:0] pl4;
        logic [1023:0] pl5;
        byte_q_t       exp1;
        byte_q_t       exp5;

        vectors     = 0;
        miscompares = 0;
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        i_src_id    = 4'h0;
        i_payload   = '0;
        i_num_bytes = 8'd0;
        i_abort     = 1'b0;
        i_tx_full   = 1'b0;

        pl1  = '0;
        pl1[31:0] = 32'h8C22_0004;
        exp1 = '{8'hA2, 8'h04, 8'h04, 8'h00, 8'h22, 8'h8C, 8'hAE};
        exp5 = '{8'hA5, 8'h04, 8'h04, 8'h00, 8'h22, 8'h8C, 8'hAE};

        // Reset state
        #12;
        check("rst/wr", 32'(o_tx_write), 32'd0);
        check("rst/data", 32'(o_tx_data), 32'h00);
        check("rst/busy", 32'(o_busy), 32'd0);
        check("rst/done", 32'(o_done), 32'd0);
        cyc();
        i_reset_n = 1'b1;
        cyc();

        // 1: basic 4-byte frame, then 2: same frame back-to-back, started in
        // the o_done cycle, with three full cycles holding the LEN byte.
        run_frame("t1", 4'h2, 8'd4, pl1, exp1, 0, -1, 0, 8);
        run_frame("t2", 4'h2, 8'd4, pl1, exp1, 2, 4, 0, 11);
        cyc();
        check("t2/done_pulse", 32'(o_done), 32'd0);

        // 3: empty payload
        run_frame("t3", 4'h6, 8'd0, pl1, '{8'hA6, 8'h00, 8'h00}, 0, -1, 0, 4);
        cyc();
        check("t3/done_pulse", 32'(o_done), 32'd0);

        // 4: oversize request clamped to 128 bytes
        pl4 = '0;
        for (int k = 0; k < 128; k++) pl4[8*k +: 8] = 8'(k * 37 + 5);
        run_frame("t4", 4'h1, 8'd200, pl4, model_frame(4'h1, 200, pl4), 0, -1, 0, 132);
        cyc();

        // 5: abort while DATA byte 2 is presented
        pl5 = '0;
        for (int k = 0; k < 17; k++) pl5[8*k +: 8] = 8'(8'hF0 - k);
        i_start = 1'b1; i_src_id = 4'h3; i_num_bytes = 8'd17; i_payload = pl5;
        cyc();
        i_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("t5/wr_c%0d", c), 32'(o_tx_write), 32'd1);
            cyc();
        end
        i_abort = 1'b1;
        #1;
        check("t5/abort_data", 32'(o_tx_data), 32'hEE);
        check("t5/abort_wr", 32'(o_tx_write), 32'd0);
        cyc();
        i_abort = 1'b0;
        #1;
        check("t5/post_busy", 32'(o_busy), 32'd0);
        check("t5/post_wr", 32'(o_tx_write), 32'd0);
        check("t5/post_done", 32'(o_done), 32'd0);
        cyc();
        check("t5/post_done2", 32'(o_done), 32'd0);
        run_frame("t5b", 4'h5, 8'd4, pl1, exp5, 0, -1, 0, 8);
        cyc();

        // 6a: asynchronous reset in the middle of DATA
        i_start = 1'b1; i_src_id = 4'h4; i_num_bytes = 8'd17; i_payload = pl5;
        cyc();
        i_start = 1'b0;
        repeat (3) cyc();
        #1;
        check("t6/pre_rst_wr", 32'(o_tx_write), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("t6/rst_wr", 32'(o_tx_write), 32'd0);
        check("t6/rst_data", 32'(o_tx_data), 32'h00);
        check("t6/rst_busy", 32'(o_busy), 32'd0);
        check("t6/rst_done", 32'(o_done), 32'd0);
        cyc();
        i_reset_n = 1'b1;
        cyc();

        // 6b: start during busy with changed inputs is ignored
        run_frame("t6b", 4'h2, 8'd4, pl1, exp1, 0, -1, 3, 8);
        cyc();
        check("t6b/done_pulse", 32'(o_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
